tick_scheduler: RTL and testbench
=================================

// Module: tick_scheduler
// PURPOSE
//  Shares one free-running prescaler (C_50Mhz -> BASE_HZ base tick) among N_CH timer channels.
//  Each channel has its own period (in base ticks), mode (periodic or one-shot), and start/stop control.
//  Sequences per-channel countdowns and emits one-cycle tick pulses for LED blink, debounce and display-scan logic.
//  Replaces per-consumer 25-bit dividers with one configurable scheduler.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency in Hz
//  BASE_HZ  1_000       base tick rate; PRE_DIV = CLK_HZ/BASE_HZ (integer, >=2)
//  N_CH     4           number of channels (1..8); CH_W = max(1,$clog2(N_CH))
//  CNT_W    16          period counter width
// PORTS
//  C_50Mhz     in   1      system clock, all logic on posedge
//  reset       in   1      synchronous, active-high reset
//  cfg_we      in   1      config write strobe
//  cfg_ch      in   CH_W   target channel
//  cfg_op      in   2      00 LOAD period/mode, 01 START, 10 STOP, 11 NOP
//  cfg_period  in   CNT_W  period in base ticks (LOAD only)
//  cfg_oneshot in   1      1 = one-shot, 0 = periodic (LOAD only)
//  cfg_ready   out  1      write accepted when cfg_we & cfg_ready
//  cfg_err     out  1      1-cycle pulse: START with period 0 or cfg_ch >= N_CH
//  base_tick   out  1      1-cycle pulse each PRE_DIV clocks
//  ch_busy     out  N_CH   channel in RUN state
//  tick_out    out  N_CH   1-cycle pulse per channel expiry
// BEHAVIOUR
//  Reset: prescaler=0; all channels IDLE; period=0, oneshot=0, count=0; all outputs 0 except cfg_ready=1.
//  Prescaler: counts 0..PRE_DIV-1 and wraps; base_tick is registered, high the cycle after the count is PRE_DIV-1.
//  Handshake: an accepted write drops cfg_ready for exactly the next cycle, then cfg_ready returns to 1.
//    - cfg_we while cfg_ready=0 is ignored (no state change, no error).
//  Channel FSM: IDLE -> RUN on START with period!=0: count<=period.
//    - RUN: on each base_tick, count decrements.
//    - Expiry = base_tick while count==1. tick_out[ch] is high the next cycle.
//    - At expiry, periodic mode reloads count<=period and stays in RUN; one-shot mode -> IDLE.
//    - STOP in RUN or IDLE -> IDLE, count<=0. STOP on the same cycle as expiry: STOP wins, no pulse.
//    - START in RUN restarts: count<=period, no pulse.
//    - LOAD in RUN updates period/oneshot; takes effect at next reload or START. Current count is untouched.
//  Errors: START with period==0 or cfg_ch>=N_CH -> cfg_err pulse next cycle, no state change; write still accepted.
//  Several channels expiring on the same base_tick all pulse in the same cycle (no arbitration loss).
//  Arithmetic is unsigned. count never underflows because expiry is detected at count==1.
//  reset mid-count: the channel returns to IDLE next cycle, no pulse.
//  ch_busy[ch] = (state==RUN), registered.
// CONFIGURATION
//  TICK_SQUARE_OUT_EN defined: adds output sq_out[N_CH].
//    - sq_out toggles in the same cycle that tick_out pulses; reset 0; holds its level when the channel is IDLE.
//    - Gives a 50% duty square wave of period 2*period/BASE_HZ (LED blink use).
//  TICK_SQUARE_OUT_EN undefined: sq_out port and toggle flops absent; all other behaviour identical.
// TESTING (sim params CLK_HZ=100, BASE_HZ=10 -> PRE_DIV=10, N_CH=4)
//  1. Release reset -> base_tick every 10 clocks; first base_tick 10 clocks after reset drops; cfg_ready=1.
//  2. LOAD ch0 period=3 periodic, START -> tick_out[0] every 30 clocks, each 1 cycle after the 3rd base_tick; ch_busy[0]=1.
//  3. LOAD ch1 period=2 one-shot, START -> one tick_out[1] pulse, then ch_busy[1]=0; no further pulses over 100 clocks.
//  4. START ch2 with period=0 -> cfg_err=1 for 1 cycle, ch_busy[2]=0; cfg_ch=5 (>=N_CH) -> cfg_err.
//  5. ch0 period=1 running; STOP issued on the expiring base_tick cycle -> no tick_out[0], ch_busy[0]=0.
//  6. Back-to-back cfg_we -> second write ignored (cfg_ready=0); reset mid-count -> all IDLE, no pulses;
//     with TICK_SQUARE_OUT_EN: sq_out[0] toggles every 30 clocks.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler: one shared prescaler driving N_CH periodic/one-shot tick channels.
// Optional per-channel square-wave outputs when TICK_SQUARE_OUT_EN is defined.
module tick_scheduler #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BASE_HZ = 1_000,
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             C_50Mhz,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_op,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_oneshot,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             base_tick,
  output logic [N_CH-1:0]  ch_busy,
  output logic [N_CH-1:0]  tick_out
`ifdef TICK_SQUARE_OUT_EN
  ,
  output logic [N_CH-1:0]  sq_out
`endif
);

  localparam int PRE_DIV = CLK_HZ / BASE_HZ;
  localparam int PRE_W   = $clog2(PRE_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);
  localparam logic [CH_W:0]    CH_LIM   = (CH_W+1)'(N_CH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             base_q, base_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;

  logic [N_CH-1:0]            st_q, st_d;
  logic [N_CH-1:0]            os_q, os_d;
  logic [N_CH-1:0]            tick_q, tick_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0][CNT_W-1:0] per_q, per_d;
`ifdef TICK_SQUARE_OUT_EN
  logic [N_CH-1:0]            sq_q, sq_d;
`endif

  logic            acc;
  logic            ch_ok;
  logic            zero_sel;
  logic            is_load, is_start, is_stop;
  logic [N_CH-1:0] wr;

  always_comb begin
    acc      = cfg_we & rdy_q;
    ch_ok    = {1'b0, cfg_ch} < CH_LIM;
    is_load  = 1'b0;
    is_start = 1'b0;
    is_stop  = 1'b0;
    unique case (cfg_op)
      OP_LOAD:  is_load  = 1'b1;
      OP_START: is_start = 1'b1;
      OP_STOP:  is_stop  = 1'b1;
      default:  ;
    endcase

    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    base_d = (pre_q == PRE_LAST);
    rdy_d  = ~acc;

    zero_sel = 1'b0;
    wr       = '0;
    st_d     = st_q;
    os_d     = os_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    tick_d   = '0;
`ifdef TICK_SQUARE_OUT_EN
    sq_d     = sq_q;
`endif

    for (int i = 0; i < N_CH; i++) begin
      wr[i] = acc & ch_ok & (cfg_ch == CH_W'(i));
      if ((cfg_ch == CH_W'(i)) && (per_q[i] == '0))
        zero_sel = 1'b1;

      if (wr[i] && is_load) begin
        per_d[i] = cfg_period;
        os_d[i]  = cfg_oneshot;
      end

      // STOP beats START, and both beat a same-cycle expiry
      if (wr[i] && is_stop) begin
        st_d[i]  = S_IDLE;
        cnt_d[i] = '0;
      end else if (wr[i] && is_start && (per_q[i] != '0)) begin
        st_d[i]  = S_RUN;
        cnt_d[i] = per_q[i];
      end else if ((st_q[i] == S_RUN) && base_q) begin
        if (cnt_q[i] == ONE) begin
          tick_d[i] = 1'b1;
`ifdef TICK_SQUARE_OUT_EN
          sq_d[i]   = ~sq_q[i];
`endif
          if (os_q[i] || (per_q[i] == '0)) begin
            st_d[i]  = S_IDLE;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = per_q[i];
          end
        end else if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - ONE;
        end else begin
          st_d[i] = S_IDLE;
        end
      end
    end

    err_d = acc & (~ch_ok | (is_start & zero_sel));
  end

  always_ff @(posedge C_50Mhz) begin
    if (reset) begin
      pre_q  <= '0;
      base_q <= 1'b0;
      rdy_q  <= 1'b1;
      err_q  <= 1'b0;
      st_q   <= '0;
      os_q   <= '0;
      tick_q <= '0;
      cnt_q  <= '0;
      per_q  <= '0;
`ifdef TICK_SQUARE_OUT_EN
      sq_q   <= '0;
`endif
    end else begin
      pre_q  <= pre_d;
      base_q <= base_d;
      rdy_q  <= rdy_d;
      err_q  <= err_d;
      st_q   <= st_d;
      os_q   <= os_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
      per_q  <= per_d;
`ifdef TICK_SQUARE_OUT_EN
      sq_q   <= sq_d;
`endif
    end
  end

  assign cfg_ready = rdy_q;
  assign cfg_err   = err_q;
  assign base_tick = base_q;
  assign ch_busy   = st_q;
  assign tick_out  = tick_q;
`ifdef TICK_SQUARE_OUT_EN
  assign sq_out    = sq_q;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed vectors and timing sequences for tick_scheduler.
// Uses CLK_HZ=100, BASE_HZ=10 (PRE_DIV=10), N_CH=4; a second N_CH=3 copy checks range errors.
module tb_tick_scheduler;

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] STOP  = 2'd2;
  localparam logic [1:0] NOP   = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        we;
  logic [1:0]  ch;
  logic [1:0]  op;
  logic [15:0] per;
  logic        os;
  logic        rdy, err, base;
  logic [3:0]  busy, tick;

  logic        b_we;
  logic [1:0]  b_ch;
  logic [1:0]  b_op;
  logic        b_rdy, b_err, b_base;
  logic [2:0]  b_busy, b_tick;
`ifdef TICK_SQUARE_OUT_EN
  logic [3:0]  sq;
  logic [2:0]  b_sq;
`endif

  tick_scheduler #(
    .CLK_HZ(100), .BASE_HZ(10), .N_CH(4), .CNT_W(16)
  ) dut (
    .C_50Mhz(clk), .reset(reset), .cfg_we(we), .cfg_ch(ch),
    .cfg_op(op), .cfg_period(per), .cfg_oneshot(os),
    .cfg_ready(rdy), .cfg_err(err), .base_tick(base),
    .ch_busy(busy), .tick_out(tick)
`ifdef TICK_SQUARE_OUT_EN
    , .sq_out(sq)
`endif
  );

  tick_scheduler #(
    .CLK_HZ(100), .BASE_HZ(10), .N_CH(3), .CNT_W(16)
  ) dut3 (
    .C_50Mhz(clk), .reset(reset), .cfg_we(b_we), .cfg_ch(b_ch),
    .cfg_op(b_op), .cfg_period(16'd0), .cfg_oneshot(1'b0),
    .cfg_ready(b_rdy), .cfg_err(b_err), .base_tick(b_base),
    .ch_busy(b_busy), .tick_out(b_tick)
`ifdef TICK_SQUARE_OUT_EN
    , .sq_out(b_sq)
`endif
  );

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic        we;
    logic [1:0]  ch;
    logic [1:0]  op;
    logic [15:0] per;
    logic        os;
    logic        rdy;
    logic        err;
    logic [3:0]  busy;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] c, input logic [1:0] o,
                    input logic [15:0] p, input logic s,
                    output logic e);
    we = 1'b1; ch = c; op = o; per = p; os = s;
    step();
    e  = err;
    we = 1'b0;
    step();
  endtask

  task automatic wait_base();
    int n;
    n = 0;
    while (!base && n < 30) begin
      step();
      n++;
    end
    chk("wait_base", {31'd0, base}, 32'd1);
  endtask

  task automatic wait_tick(input int c, input int bound, output int n,
                           output int nb, output logic prev,
                           output logic found);
    n = 0; nb = 0; prev = 1'b0;
    while (!tick[c] && n < bound) begin
      prev = base;
      if (base) nb++;
      step();
      n++;
    end
    found = tick[c];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, nb;
    logic prev, found, e, bad;

    tbl[0]  = '{1'b1, 2'd2, LOAD,  16'd0,  1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{1'b0, 2'd2, NOP,   16'd0,  1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[2]  = '{1'b1, 2'd2, START, 16'd0,  1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[3]  = '{1'b0, 2'd2, NOP,   16'd0,  1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[4]  = '{1'b1, 2'd3, LOAD,  16'd40, 1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[5]  = '{1'b1, 2'd3, START, 16'd0,  1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[6]  = '{1'b1, 2'd3, START, 16'd0,  1'b0, 1'b0, 1'b0, 4'b1000};
    tbl[7]  = '{1'b1, 2'd3, STOP,  16'd0,  1'b0, 1'b1, 1'b0, 4'b1000};
    tbl[8]  = '{1'b1, 2'd3, STOP,  16'd0,  1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[9]  = '{1'b1, 2'd3, START, 16'd0,  1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[10] = '{1'b1, 2'd3, START, 16'd0,  1'b0, 1'b0, 1'b0, 4'b1000};
    tbl[11] = '{1'b1, 2'd3, LOAD,  16'd5,  1'b0, 1'b1, 1'b0, 4'b1000};
    tbl[12] = '{1'b1, 2'd3, NOP,   16'd0,  1'b0, 1'b0, 1'b0, 4'b1000};
    tbl[13] = '{1'b0, 2'd3, NOP,   16'd0,  1'b0, 1'b1, 1'b0, 4'b1000};
    tbl[14] = '{1'b1, 2'd3, STOP,  16'd0,  1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[15] = '{1'b0, 2'd3, NOP,   16'd0,  1'b0, 1'b1, 1'b0, 4'b0000};

    reset = 1'b1; we = 1'b0; ch = '0; op = NOP; per = '0; os = 1'b0;
    b_we = 1'b0; b_ch = '0; b_op = NOP;
    repeat (3) step();
    chk("rst rdy",  {31'd0, rdy},  32'd1);
    chk("rst err",  {31'd0, err},  32'd0);
    chk("rst base", {31'd0, base}, 32'd0);
    chk("rst busy", {28'd0, busy}, 32'd0);
    chk("rst tick", {28'd0, tick}, 32'd0);

    reset = 1'b0;
    n = 0;
    do begin step(); n++; end while (!base && n < 30);
    chk("first base latency", n, 10);
    n = 0;
    do begin step(); n++; end while (!base && n < 30);
    chk("base period", n, 10);
    chk("rdy idle", {31'd0, rdy}, 32'd1);

    b_we = 1'b1; b_ch = 2'd3; b_op = START;
    step();
    chk("ch>=N_CH err", {31'd0, b_err}, 32'd1);
    b_we = 1'b0;
    step();
    chk("err one cycle", {31'd0, b_err}, 32'd0);
    b_we = 1'b1; b_ch = 2'd2; b_op = START;
    step();
    chk("period0 err n3", {31'd0, b_err}, 32'd1);
    b_we = 1'b0;
    step();
    chk("n3 busy", {29'd0, b_busy}, 32'd0);
    chk("n3 tick", {29'd0, b_tick}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      we = tbl[i].we; ch = tbl[i].ch; op = tbl[i].op;
      per = tbl[i].per; os = tbl[i].os;
      step();
      chk($sformatf("vec%0d rdy", i),  {31'd0, rdy},  {31'd0, tbl[i].rdy});
      chk($sformatf("vec%0d err", i),  {31'd0, err},  {31'd0, tbl[i].err});
      chk($sformatf("vec%0d busy", i), {28'd0, busy}, {28'd0, tbl[i].busy});
    end
    we = 1'b0;

    wait_base();
    wr(2'd0, LOAD, 16'd3, 1'b0, e);
    wr(2'd0, START, 16'd0, 1'b0, e);
    wait_tick(0, 60, n, nb, prev, found);
    chk("p3 found", {31'd0, found}, 32'd1);
    chk("p3 bases", nb, 3);
    chk("p3 after base", {31'd0, prev}, 32'd1);
    chk("p3 busy0", {31'd0, busy[0]}, 32'd1);
`ifdef TICK_SQUARE_OUT_EN
    chk("sq0 rise", {31'd0, sq[0]}, 32'd1);
`endif
    step();
    chk("p3 pulse width", {31'd0, tick[0]}, 32'd0);
    wait_tick(0, 60, n, nb, prev, found);
    chk("p3 interval", n + 1, 30);
    chk("p3 bases2", nb, 3);
`ifdef TICK_SQUARE_OUT_EN
    chk("sq0 fall", {31'd0, sq[0]}, 32'd0);
`endif

    wr(2'd1, LOAD, 16'd2, 1'b1, e);
    wr(2'd1, START, 16'd0, 1'b0, e);
    wait_tick(1, 60, n, nb, prev, found);
    chk("os found", {31'd0, found}, 32'd1);
    chk("os bases", nb, 2);
    chk("os busy", {28'd0, busy}, 32'd1);
    step();
    wait_tick(1, 100, n, nb, prev, found);
    chk("os no repeat", {31'd0, found}, 32'd0);

    wr(2'd0, LOAD, 16'd1, 1'b0, e);
    wait_tick(0, 40, n, nb, prev, found);
    chk("reload found", {31'd0, found}, 32'd1);
    step();
    wait_tick(0, 40, n, nb, prev, found);
    chk("p1 interval", n + 1, 10);
    wait_base();
    we = 1'b1; ch = 2'd0; op = STOP;
    step();
    we = 1'b0;
    chk("stop@expiry tick", {31'd0, tick[0]}, 32'd0);
    chk("stop@expiry busy", {31'd0, busy[0]}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tick[0]) bad = 1'b1;
    end
    chk("stopped quiet", {31'd0, bad}, 32'd0);

    wait_base();
    wr(2'd0, LOAD, 16'd2, 1'b0, e);
    wr(2'd1, LOAD, 16'd2, 1'b0, e);
    wr(2'd0, START, 16'd0, 1'b0, e);
    wr(2'd1, START, 16'd0, 1'b0, e);
    wait_tick(0, 40, n, nb, prev, found);
    chk("dual tick", {28'd0, tick}, 32'h3);
    chk("dual bases", nb, 2);
    chk("dual busy", {28'd0, busy}, 32'h3);

    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst busy", {28'd0, busy}, 32'd0);
    chk("midrst tick", {28'd0, tick}, 32'd0);
    chk("midrst rdy",  {31'd0, rdy},  32'd1);
    chk("midrst base", {31'd0, base}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (tick != 4'd0 || busy != 4'd0) bad = 1'b1;
    end
    chk("post rst quiet", {31'd0, bad}, 32'd0);
    wr(2'd0, START, 16'd0, 1'b0, e);
    chk("post rst period0 err", {31'd0, e}, 32'd1);
    chk("post rst idle", {28'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
